sensor_pattern_gen: RTL

SENSOR_PATTERN_GEN -- requirements
Module: sensor_pattern_gen

---
 rtl/veh_pkg.sv | 48 ++++
 rtl/phase_timer.sv | 27 ++
 rtl/sensor_pattern_gen.sv | 135 +++++++++++++
 3 files changed

// File: rtl/veh_pkg.sv
// Purpose: shared encodings for the vehicle access-control family (FSM states, direction, sensor phases).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package veh_pkg;

  // Sequence generator states; the core's control decoder uses the same encoding.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PH1  = 3'd1,
    ST_PH2  = 3'd2,
    ST_PH3  = 3'd3,
    ST_PH4  = 3'd4,
    ST_DONE = 3'd5,
    ST_REJ  = 3'd6
  } veh_state_t;

  localparam logic DIR_ENTER = 1'b0;
  localparam logic DIR_EXIT  = 1'b1;

  // {a,b} per phase for a car driving in: outer sensor first, then inner.
  localparam logic [1:0] AB_ENT_PH1 = 2'b10;
  localparam logic [1:0] AB_ENT_PH2 = 2'b11;
  localparam logic [1:0] AB_ENT_PH3 = 2'b01;
  localparam logic [1:0] AB_ENT_PH4 = 2'b00;

  // {a,b} per phase for a car driving out: inner sensor first, then outer.
  localparam logic [1:0] AB_EXT_PH1 = 2'b01;
  localparam logic [1:0] AB_EXT_PH2 = 2'b11;
  localparam logic [1:0] AB_EXT_PH3 = 2'b10;
  localparam logic [1:0] AB_EXT_PH4 = 2'b00;

  localparam logic [1:0] AB_OFF = 2'b00;

  // Sensor levels to present while in a given state for a given direction.
  function automatic logic [1:0] phase_ab(input veh_state_t st, input logic dir);
    logic [1:0] ab;
    ab = AB_OFF;
    case (st)
      ST_PH1:  ab = (dir == DIR_ENTER) ? AB_ENT_PH1 : AB_EXT_PH1;
      ST_PH2:  ab = (dir == DIR_ENTER) ? AB_ENT_PH2 : AB_EXT_PH2;
      ST_PH3:  ab = (dir == DIR_ENTER) ? AB_ENT_PH3 : AB_EXT_PH3;
      ST_PH4:  ab = (dir == DIR_ENTER) ? AB_ENT_PH4 : AB_EXT_PH4;
      default: ab = AB_OFF;
    endcase
    return ab;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Purpose: loadable 8-bit down-counter timing how long each sensor phase is held.
// Latency: expired rises load_val cycles after the load edge (same cycle when load_val is 0).
// Backpressure: none; load always wins over counting.
module phase_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       expired
);

  logic [7:0] r_cnt;

  // Reload on phase entry, otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= 8'd0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != 8'd0) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign expired = (r_cnt == 8'd0);

endmodule

// File: rtl/sensor_pattern_gen.sv
// Purpose: emits car entry/exit sensor sequences on a/b and tracks a reference occupancy count.
// Latency: request at edge k -> PH1 on a/b at k+1, done at k+4*DWELL+1, ready again at k+4*DWELL+2.
// Backpressure: requests are taken only while ready is high; anything else is dropped, never queued.
module sensor_pattern_gen
  import veh_pkg::*;
#(
  parameter int DWELL    = 4,
  parameter int MAX_CARS = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter_req,
  input  logic       exit_req,
  output logic       ready,
  output logic       a,
  output logic       b,
  output logic       done,
  output logic       reject,
  output logic [3:0] cnt_model
);

  // Timer counts down to zero, so a phase of DWELL cycles loads DWELL-1.
  localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);
  localparam logic [3:0] MAX_C    = 4'(MAX_CARS);

  veh_state_t r_state;
  veh_state_t w_state_nxt;
  logic       r_dir;
  logic       w_dir_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       w_load;
  logic       w_expired;
  logic [1:0] w_ab_nxt;

  phase_timer u_phase_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .load_val (DWELL_M1),
    .expired  (w_expired)
  );

  // State, direction and occupancy registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_dir   <= DIR_ENTER;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: accept/reject in IDLE, walk the four phases, bump the count on entry to DONE.
  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enter_req) begin
          // Enter has priority when both requests arrive together.
          w_dir_nxt = DIR_ENTER;
          if (r_cnt == MAX_C) begin
            w_state_nxt = ST_REJ;
          end else begin
            w_state_nxt = ST_PH1;
            w_load      = 1'b1;
          end
        end else if (exit_req) begin
          w_dir_nxt = DIR_EXIT;
          if (r_cnt == 4'd0) begin
            w_state_nxt = ST_REJ;
          end else begin
            w_state_nxt = ST_PH1;
            w_load      = 1'b1;
          end
        end
      end
      ST_PH1: begin
        if (w_expired) begin
          w_state_nxt = ST_PH2;
          w_load      = 1'b1;
        end
      end
      ST_PH2: begin
        if (w_expired) begin
          w_state_nxt = ST_PH3;
          w_load      = 1'b1;
        end
      end
      ST_PH3: begin
        if (w_expired) begin
          w_state_nxt = ST_PH4;
          w_load      = 1'b1;
        end
      end
      ST_PH4: begin
        if (w_expired) begin
          w_state_nxt = ST_DONE;
          // Capacity was checked at acceptance, so neither direction can wrap here.
          w_cnt_nxt   = (r_dir == DIR_ENTER) ? (r_cnt + 4'd1) : (r_cnt - 4'd1);
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      ST_REJ:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_ab_nxt = phase_ab(w_state_nxt, w_dir_nxt);

  // Registered sensor and status outputs, decoded from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a      <= 1'b0;
      b      <= 1'b0;
      done   <= 1'b0;
      reject <= 1'b0;
    end else begin
      a      <= w_ab_nxt[1];
      b      <= w_ab_nxt[0];
      done   <= (w_state_nxt == ST_DONE);
      reject <= (w_state_nxt == ST_REJ);
    end
  end

  assign ready     = (r_state == ST_IDLE);
  assign cnt_model = r_cnt;

endmodule
